// File: rtl/fifo_apb_adc_if.sv
// fifo_apb_adc_if: bus bundle between an ADC-side producer / APB-side consumer
// and the fifo_apb_adc queue.
//
// Signals:
//   adc_wr_en, adc_data   push request and data (producer -> FIFO)
//   apb_rd_en             pop request (consumer -> FIFO)
//   fifo_clear            synchronous flush (controller -> FIFO)
//   apb_rd_data           show-ahead head-of-queue data (FIFO -> consumer)
//   fifo_full/fifo_empty  occupancy flags
//   fifo_count            stored entries, 0..DEPTH
//   ovf_err, udf_err      sticky error flags, present only with FIFO_APB_ADC_ERR_FLAGS_EN
//
// Modports: master drives requests and observes status; slave is the FIFO.
interface fifo_apb_adc_if #(
  parameter int unsigned DATA_WIDTH = 56,
  parameter int unsigned DEPTH      = 16
);
  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  logic                  adc_wr_en;
  logic [DATA_WIDTH-1:0] adc_data;
  logic                  apb_rd_en;
  logic                  fifo_clear;
  logic [DATA_WIDTH-1:0] apb_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CountW-1:0]     fifo_count;
`ifdef FIFO_APB_ADC_ERR_FLAGS_EN
  logic                  ovf_err;
  logic                  udf_err;
`endif

  modport master (
    output adc_wr_en,
    output adc_data,
    output apb_rd_en,
    output fifo_clear,
    input  apb_rd_data,
    input  fifo_full,
    input  fifo_empty,
`ifdef FIFO_APB_ADC_ERR_FLAGS_EN
    input  ovf_err,
    input  udf_err,
`endif
    input  fifo_count
  );

  modport slave (
    input  adc_wr_en,
    input  adc_data,
    input  apb_rd_en,
    input  fifo_clear,
    output apb_rd_data,
    output fifo_full,
    output fifo_empty,
`ifdef FIFO_APB_ADC_ERR_FLAGS_EN
    output ovf_err,
    output udf_err,
`endif
    output fifo_count
  );

endinterface

// File: rtl/fifo_apb_adc.sv
// fifo_apb_adc: single-clock show-ahead FIFO buffering ADC samples for an APB reader.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (pointers cleared, queue emptied)
//   bus   fifo_apb_adc_if.slave: adc_wr_en/adc_data push, apb_rd_en pop,
//         fifo_clear flush, apb_rd_data head data (zero when empty),
//         fifo_full, fifo_empty, fifo_count status.
//
// Optional feature: define FIFO_APB_ADC_ERR_FLAGS_EN to add sticky ovf_err
// (dropped write) and udf_err (ignored read) flags, cleared by rst or fifo_clear.
//
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter; fifo_count is the pointer difference.
module fifo_apb_adc #(
  parameter int unsigned DATA_WIDTH = 56,
  parameter int unsigned DEPTH      = 16
) (
  input logic              clk,
  input logic              rst,
  fifo_apb_adc_if.slave    bus
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
    $error("fifo_apb_adc: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

  logic [AddrW-1:0] wr_idx;
  logic [AddrW-1:0] rd_idx;

  logic empty;
  logic full;
  logic do_wr;
  logic do_rd;
  logic drop_wr;
  logic drop_rd;

  assign wr_idx = wr_ptr_q[AddrW-1:0];
  assign rd_idx = rd_ptr_q[AddrW-1:0];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_idx == rd_idx) && (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]);

  // A read on a full FIFO frees the slot being written in the same edge, so
  // the write is accepted. A read on an empty FIFO is never accepted, which
  // also covers the write+read-while-empty case (write only).
  assign do_rd   = bus.apb_rd_en && !empty;
  assign do_wr   = bus.adc_wr_en && (!full || do_rd);
  assign drop_wr = bus.adc_wr_en && !do_wr;
  assign drop_rd = bus.apb_rd_en && empty;

  // Pointer next-state; clear overrides any concurrent push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.fifo_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the empty gate on apb_rd_data hides stale entries.
  always_ff @(posedge clk) begin
    if (do_wr && !bus.fifo_clear) begin
      mem_q[wr_idx] <= bus.adc_data;
    end
  end

  assign bus.apb_rd_data = empty ? '0 : mem_q[rd_idx];
  assign bus.fifo_empty  = empty;
  assign bus.fifo_full   = full;
  assign bus.fifo_count  = wr_ptr_q - rd_ptr_q;

`ifdef FIFO_APB_ADC_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (bus.fifo_clear) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (drop_wr) begin
        ovf_d = 1'b1;
      end
      if (drop_rd) begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.ovf_err = ovf_q;
  assign bus.udf_err = udf_q;
`else
  // Without the error flags the drop conditions have no consumer.
  logic unused_drop;
  assign unused_drop = drop_wr ^ drop_rd;
`endif

endmodule

// File: tb/tb_fifo_apb_adc.sv
module tb_fifo_apb_adc;

  localparam int unsigned DW = 56;
  localparam int unsigned DP = 16;

  logic clk;
  logic rst;

  int pass_cnt;
  int total_cnt;

  localparam logic [DW-1:0] D0 = 56'h0123456789ABCD;

  fifo_apb_adc_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  fifo_apb_adc #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Called at a negedge: apply one cycle of inputs, return at the next negedge.
  task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
    bus.adc_wr_en  = wr;
    bus.adc_data   = d;
    bus.apb_rd_en  = rd;
    bus.fifo_clear = clr;
    @(negedge clk);
    bus.adc_wr_en  = 1'b0;
    bus.apb_rd_en  = 1'b0;
    bus.fifo_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.adc_wr_en = 1'b1;
    bus.adc_data = 56'h1;
    bus.apb_rd_en = 1'b0;
    bus.fifo_clear = 1'b0;
    #3;
    total_cnt++;
    if (bus.fifo_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.fifo_empty);
    else pass_cnt++;
    total_cnt++;
    if (bus.fifo_full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.fifo_full);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus.fifo_count !== 5'd0) $display("FAIL reset_count: got %0d want 0", bus.fifo_count);
    else pass_cnt++;
    total_cnt++;
    if (bus.apb_rd_data !== '0) $display("FAIL reset_data: got %h want 0", bus.apb_rd_data);
    else pass_cnt++;
`ifdef FIFO_APB_ADC_ERR_FLAGS_EN
    total_cnt++;
    if ({bus.ovf_err, bus.udf_err} !== 2'b00)
      $display("FAIL reset_errs: got %b want 00", {bus.ovf_err, bus.udf_err});
    else pass_cnt++;
`endif
    bus.adc_wr_en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, D0 + 56'(k), 1'b0, 1'b0);
      if (k == 0) begin
        total_cnt++;
        if (bus.apb_rd_data !== D0) $display("FAIL first_visible: got %h want %h", bus.apb_rd_data, D0);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (bus.fifo_count !== 5'd5) $display("FAIL count5: got %0d want 5", bus.fifo_count);
    else pass_cnt++;
    total_cnt++;
    if (bus.fifo_empty !== 1'b0) $display("FAIL empty5: got %b want 0", bus.fifo_empty);
    else pass_cnt++;
    total_cnt++;
    if (bus.apb_rd_data !== D0) $display("FAIL head5: got %h want %h", bus.apb_rd_data, D0);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if (bus.apb_rd_data !== D0 + 56'(k))
        $display("FAIL pop_order[%0d]: got %h want %h", k, bus.apb_rd_data, D0 + 56'(k));
      else pass_cnt++;
      step(1'b0, '0, 1'b1, 1'b0);
    end
    total_cnt++;
    if (bus.fifo_empty !== 1'b1) $display("FAIL drained_empty: got %b want 1", bus.fifo_empty);
    else pass_cnt++;
    total_cnt++;
    if (bus.apb_rd_data !== '0) $display("FAIL drained_data: got %h want 0", bus.apb_rd_data);
    else pass_cnt++;
    // Read while empty is ignored.
    step(1'b0, '0, 1'b1, 1'b0);
    total_cnt++;
    if (bus.fifo_count !== 5'd0) $display("FAIL empty_read_count: got %0d want 0", bus.fifo_count);
    else pass_cnt++;
`ifdef FIFO_APB_ADC_ERR_FLAGS_EN
    total_cnt++;
    if (bus.udf_err !== 1'b1) $display("FAIL udf_set: got %b want 1", bus.udf_err);
    else pass_cnt++;
    step(1'b0, '0, 1'b0, 1'b1);
    total_cnt++;
    if (bus.udf_err !== 1'b0) $display("FAIL udf_clear: got %b want 0", bus.udf_err);
    else pass_cnt++;
`endif
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 56'h00A50000000000 + 56'(k), 1'b0, 1'b0);
      if (k == 14) begin
        total_cnt++;
        if (bus.fifo_full !== 1'b0) $display("FAIL full_at15: got %b want 0", bus.fifo_full);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (bus.fifo_full !== 1'b1) $display("FAIL full_at16: got %b want 1", bus.fifo_full);
    else pass_cnt++;
    total_cnt++;
    if (bus.fifo_count !== 5'd16) $display("FAIL count16: got %0d want 16", bus.fifo_count);
    else pass_cnt++;
    step(1'b1, 56'hFFFFFFFFFFFFFF, 1'b0, 1'b0);
    total_cnt++;
    if (bus.fifo_count !== 5'd16) $display("FAIL drop_count: got %0d want 16", bus.fifo_count);
    else pass_cnt++;
`ifdef FIFO_APB_ADC_ERR_FLAGS_EN
    total_cnt++;
    if (bus.ovf_err !== 1'b1) $display("FAIL ovf_set: got %b want 1", bus.ovf_err);
    else pass_cnt++;
`endif
    for (int k = 0; k < 16; k++) begin
      total_cnt++;
      if (bus.apb_rd_data !== 56'h00A50000000000 + 56'(k))
        $display("FAIL ovf_read[%0d]: got %h want %h", k, bus.apb_rd_data,
                 56'h00A50000000000 + 56'(k));
      else pass_cnt++;
      step(1'b0, '0, 1'b1, 1'b0);
    end
    total_cnt++;
    if (bus.fifo_empty !== 1'b1) $display("FAIL ovf_drained: got %b want 1", bus.fifo_empty);
    else pass_cnt++;
    step(1'b0, '0, 1'b0, 1'b1);
`ifdef FIFO_APB_ADC_ERR_FLAGS_EN
    total_cnt++;
    if (bus.ovf_err !== 1'b0) $display("FAIL ovf_clear: got %b want 0", bus.ovf_err);
    else pass_cnt++;
`endif
  endtask

  task automatic test_clear();
    for (int k = 0; k < 3; k++) step(1'b1, 56'h00C00000000000 + 56'(k), 1'b0, 1'b0);
    total_cnt++;
    if (bus.fifo_count !== 5'd3) $display("FAIL clr_pre_count: got %0d want 3", bus.fifo_count);
    else pass_cnt++;
    step(1'b1, 56'h00DEAD00000000, 1'b0, 1'b1);
    total_cnt++;
    if (bus.fifo_empty !== 1'b1) $display("FAIL clr_empty: got %b want 1", bus.fifo_empty);
    else pass_cnt++;
    total_cnt++;
    if (bus.fifo_count !== 5'd0) $display("FAIL clr_count: got %0d want 0", bus.fifo_count);
    else pass_cnt++;
    total_cnt++;
    if (bus.apb_rd_data !== '0) $display("FAIL clr_data: got %h want 0", bus.apb_rd_data);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // Write+read on empty: only the write happens.
    step(1'b1, 56'h00B1, 1'b1, 1'b0);
    total_cnt++;
    if (bus.fifo_count !== 5'd1) $display("FAIL wr_rd_empty_count: got %0d want 1", bus.fifo_count);
    else pass_cnt++;
    total_cnt++;
    if (bus.apb_rd_data !== 56'h00B1) $display("FAIL wr_rd_empty_data: got %h want b1", bus.apb_rd_data);
    else pass_cnt++;
    // Write+read mid-occupancy: count holds, head advances.
    step(1'b1, 56'h00B2, 1'b0, 1'b0);
    step(1'b1, 56'h00B3, 1'b1, 1'b0);
    total_cnt++;
    if (bus.fifo_count !== 5'd2) $display("FAIL wr_rd_mid_count: got %0d want 2", bus.fifo_count);
    else pass_cnt++;
    total_cnt++;
    if (bus.apb_rd_data !== 56'h00B2) $display("FAIL wr_rd_mid_data: got %h want b2", bus.apb_rd_data);
    else pass_cnt++;
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_full_stream();
    logic [DW-1:0] q[$];
    logic [DW-1:0] v;
    for (int k = 0; k < 16; k++) begin
      v = 56'h00F00000000000 + 56'(k);
      q.push_back(v);
      step(1'b1, v, 1'b0, 1'b0);
    end
    for (int c = 0; c < 40; c++) begin
      v = 56'h0BEE0000000000 + 56'(c);
      total_cnt++;
      if (bus.apb_rd_data !== q[0])
        $display("FAIL stream_data[%0d]: got %h want %h", c, bus.apb_rd_data, q[0]);
      else pass_cnt++;
      step(1'b1, v, 1'b1, 1'b0);
      void'(q.pop_front());
      q.push_back(v);
      total_cnt++;
      if (bus.fifo_full !== 1'b1) $display("FAIL stream_full[%0d]: got %b want 1", c, bus.fifo_full);
      else pass_cnt++;
    end
    for (int k = 0; k < 16; k++) begin
      total_cnt++;
      if (bus.apb_rd_data !== q[0])
        $display("FAIL stream_tail[%0d]: got %h want %h", k, bus.apb_rd_data, q[0]);
      else pass_cnt++;
      void'(q.pop_front());
      step(1'b0, '0, 1'b1, 1'b0);
    end
`ifdef FIFO_APB_ADC_ERR_FLAGS_EN
    total_cnt++;
    if (bus.ovf_err !== 1'b0) $display("FAIL stream_no_ovf: got %b want 0", bus.ovf_err);
    else pass_cnt++;
`endif
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 56'h00E00000000000 + 56'(k), 1'b0, 1'b0);
    bus.adc_wr_en = 1'b1;
    bus.adc_data = 56'h00E0000000000F;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.fifo_empty !== 1'b1) $display("FAIL arst_empty: got %b want 1", bus.fifo_empty);
    else pass_cnt++;
    total_cnt++;
    if (bus.fifo_count !== 5'd0) $display("FAIL arst_count: got %0d want 0", bus.fifo_count);
    else pass_cnt++;
    total_cnt++;
    if (bus.apb_rd_data !== '0) $display("FAIL arst_data: got %h want 0", bus.apb_rd_data);
    else pass_cnt++;
    @(negedge clk);
    bus.adc_wr_en = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 16; k++) step(1'b1, 56'h00770000000000 + 56'(k), 1'b0, 1'b0);
    total_cnt++;
    if (bus.fifo_full !== 1'b1) $display("FAIL arst_refill_full: got %b want 1", bus.fifo_full);
    else pass_cnt++;
    total_cnt++;
    if (bus.apb_rd_data !== 56'h00770000000000)
      $display("FAIL arst_refill_head: got %h want 770000000000", bus.apb_rd_data);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_clear();
    test_back_to_back();
    test_full_stream();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_apb_adc.md
FIFO_APB_ADC -- requirements
Module: fifo_apb_adc

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_WIDTH, default 56, SHALL set the entry width in bits.
REQ-003 Parameter DEPTH, default 16, SHALL set the entry count; it must be a power of two, >= 2.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 adc_wr_en  input  1  push request from the ADC side.
REQ-007 adc_data  input  DATA_WIDTH  push data.
REQ-008 fifo_full  output  1  high when DEPTH entries are stored.
REQ-009 apb_rd_en  input  1  pop request from the APB side.
REQ-010 apb_rd_data  output  DATA_WIDTH  head-of-queue data (show-ahead).
REQ-011 fifo_empty  output  1  high when 0 entries are stored.
REQ-012 fifo_clear  input  1  synchronous flush.
REQ-013 fifo_count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.

Function
REQ-014 Storage SHALL be DEPTH x DATA_WIDTH registers with write and read pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
REQ-015 At a rising clk edge with adc_wr_en=1 and fifo_full=0, adc_data SHALL be written at the write pointer and the write pointer SHALL increment modulo 2*DEPTH.
REQ-016 At a rising clk edge with apb_rd_en=1 and fifo_empty=0, the read pointer SHALL increment modulo 2*DEPTH.
REQ-017 apb_rd_data SHALL combinationally present the entry at the read pointer whenever fifo_empty=0, with zero latency, and SHALL be all-zero when fifo_empty=1.
REQ-018 Written data SHALL be visible on apb_rd_data in the cycle after the write edge if the FIFO was empty.
REQ-019 fifo_empty SHALL be 1 exactly when the pointers are equal; fifo_full SHALL be 1 exactly when the index bits are equal and the wrap bits differ; both are registered-pointer derived, with no extra latency.
REQ-020 A write while full SHALL be dropped; FIFO contents and pointers SHALL be unchanged.
REQ-021 A read while empty SHALL be ignored; the pointers SHALL be unchanged.
REQ-022 Simultaneous write and read while non-empty and non-full SHALL perform both; fifo_count SHALL be unchanged.
REQ-023 Simultaneous write and read while full SHALL perform both; the read frees the slot being written.
REQ-024 Simultaneous write and read while empty SHALL perform only the write.
REQ-025 fifo_clear=1 at a rising edge SHALL set both pointers to 0 and override any concurrent write or read; storage contents need not be cleared.
REQ-026 Pointers SHALL wrap seamlessly; data order SHALL be preserved across any number of wraps.

Reset
REQ-027 While rst=1, both pointers SHALL be 0 immediately, independent of clk.
REQ-028 During reset, fifo_empty=1, fifo_full=0, fifo_count=0 and apb_rd_data=0.
REQ-029 Storage contents SHALL NOT require reset.
REQ-030 Reset asserted mid-operation SHALL discard all entries.
REQ-031 Operation SHALL resume on the first rising edge after rst deasserts.

Configuration
REQ-032 When macro FIFO_APB_ADC_ERR_FLAGS_EN is defined, the block SHALL add outputs ovf_err (1) and udf_err (1).
REQ-033 ovf_err SHALL set sticky on a dropped write (REQ-020); udf_err SHALL set sticky on an ignored read (REQ-021).
REQ-034 ovf_err and udf_err SHALL be cleared by rst or fifo_clear.
REQ-035 When FIFO_APB_ADC_ERR_FLAGS_EN is undefined, these ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Reset, then 5 writes of distinct 56-bit values (e.g. 0x0123456789ABCD + k) -> fifo_count=5, fifo_empty=0, and apb_rd_data equals the first value before any read.
REQ-037 Then 5 pops, sampling apb_rd_data before each pop edge -> the values appear in write order and fifo_empty=1 after the 5th pop.
REQ-038 16 writes then a 17th write of 0xFF..FF -> fifo_full=1 after the 16th write; the 17th is dropped, so all 16 reads return the original values (and ovf_err=1 if enabled).
REQ-039 With 3 entries stored, pulse fifo_clear together with adc_wr_en for one cycle -> fifo_empty=1, fifo_count=0 and apb_rd_data=0 on the next cycle.
REQ-040 Full FIFO with simultaneous write and read for 40 cycles -> fifo_full stays 1, and the output sequence matches a reference queue across pointer wraps.
REQ-041 Assert rst asynchronously mid-burst between clock edges -> fifo_empty=1 immediately; writes after release start at entry 0.
